// File: rtl/hex_uart_sender.sv
// Streams a captured DATA_W-bit value to the host UART as ASCII hex, MS nibble first,
// optionally followed by CR,LF. One txclk strobe per character, paced by txready.
module hex_uart_sender #(
   parameter int DATA_W    = 8,
   parameter int SEND_CRLF = 1,
   parameter int UPPERCASE = 1
) (
   input  logic              hz100,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data,
   input  logic              txready,
   output logic [7:0]        txdata,
   output logic              txclk,
   output logic              busy,
   output logic              done
);

   localparam int NDIG  = DATA_W / 4;
   localparam int NCH   = NDIG + ((SEND_CRLF != 0) ? 2 : 0);
   localparam int IDX_W = $clog2(NCH + 1);
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(NCH - 1);
   localparam logic [IDX_W-1:0] NDIG_I = IDX_W'(NDIG);
   // 'A' - 10 or 'a' - 10, so the nibble value can be added directly
   localparam logic [7:0] ALPHA_BASE = (UPPERCASE != 0) ? 8'h37 : 8'h57;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STROBE} state_t;

   state_t            state, state_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [7:0]        txdata_n;
   logic              txclk_n, busy_n, done_n;
   logic [3:0]        nib;
   logic [7:0]        ch;

   // Digits are taken from the top of a left-shifting copy of the captured value
   always_comb begin
      nib = shreg[DATA_W-1 -: 4];
      if (idx < NDIG_I)
         ch = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (ALPHA_BASE + {4'h0, nib});
      else if (idx == NDIG_I)
         ch = 8'h0D;
      else
         ch = 8'h0A;
   end

   always_ff @(posedge hz100 or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         shreg  <= '0;
         idx    <= '0;
         txdata <= '0;
         txclk  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         shreg  <= shreg_n;
         idx    <= idx_n;
         txdata <= txdata_n;
         txclk  <= txclk_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      idx_n    = idx;
      txdata_n = txdata;
      txclk_n  = 1'b0;
      busy_n   = busy;
      done_n   = 1'b0;
      case (state)
         S_IDLE: begin
            busy_n = 1'b0;
            if (start) begin
               shreg_n = data;
               idx_n   = '0;
               busy_n  = 1'b1;
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (txready) begin
               txdata_n = ch;
               txclk_n  = 1'b1;
               shreg_n  = shreg << 4;
               state_n  = S_STROBE;
            end
         end
         S_STROBE: begin
            if (idx == LAST) begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = S_IDLE;
            end else begin
               idx_n   = idx + 1'b1;
               state_n = S_WAIT;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hex_uart_sender.sv
// Directed bench for hex_uart_sender: three parameterisations, expected characters
// queued at each start and popped on every txclk strobe.
module tb_hex_uart_sender;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        s0, r0, s1, r1, s2, r2;
   logic [7:0]  d0, d1;
   logic [15:0] d2;
   logic [7:0]  x0, x1, x2;
   logic        c0, c1, c2, b0, b1, b2, f0, f1, f2;

   int checks = 0;
   int failures = 0;
   int n0 = 0, n1 = 0, n2 = 0;
   logic p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;
   logic [7:0] q0[$], q1[$], q2[$];

   hex_uart_sender u0 (
      .hz100(clk), .reset(rst), .start(s0), .data(d0), .txready(r0),
      .txdata(x0), .txclk(c0), .busy(b0), .done(f0));

   hex_uart_sender #(.DATA_W(8), .SEND_CRLF(0), .UPPERCASE(0)) u1 (
      .hz100(clk), .reset(rst), .start(s1), .data(d1), .txready(r1),
      .txdata(x1), .txclk(c1), .busy(b1), .done(f1));

   hex_uart_sender #(.DATA_W(16), .SEND_CRLF(1), .UPPERCASE(1)) u2 (
      .hz100(clk), .reset(rst), .start(s2), .data(d2), .txready(r2),
      .txdata(x2), .txclk(c2), .busy(b2), .done(f2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int sel, input logic [7:0] c);
      case (sel)
         0: q0.push_back(c);
         1: q1.push_back(c);
         default: q2.push_back(c);
      endcase
   endtask

   task automatic push_hex(input int sel, input logic [31:0] v, input int ndig,
                           input bit upper, input bit crlf);
      logic [3:0] nb;
      logic [7:0] c;
      for (int i = ndig - 1; i >= 0; i--) begin
         nb = v[4*i +: 4];
         if (nb < 4'd10) c = 8'h30 + 8'(nb);
         else c = (upper ? 8'h41 : 8'h61) + 8'(nb) - 8'd10;
         push(sel, c);
      end
      if (crlf) begin
         push(sel, 8'h0D);
         push(sel, 8'h0A);
      end
   endtask

   task automatic wait_done(input int sel, input int max, output int n);
      logic dn, bz;
      n = 0;
      dn = 1'b0;
      while (!dn && n < max) begin
         tick();
         n++;
         case (sel)
            0: begin dn = f0; bz = b0; end
            1: begin dn = f1; bz = b1; end
            default: begin dn = f2; bz = b2; end
         endcase
         if (!dn) chk("busy_during_transfer", 32'(bz), 32'd1);
      end
      if (!dn) n = -1;
   endtask

   always @(negedge clk) begin
      if (c0) begin
         n0++;
         chk("u0_strobe_gap", 32'(p0), 32'd0);
         if (q0.size() == 0) chk("u0_extra_strobe", 32'(q0.size()), 32'd1);
         else chk("u0_char", 32'(x0), 32'(q0.pop_front()));
      end
      p0 = c0;
   end

   always @(negedge clk) begin
      if (c1) begin
         n1++;
         chk("u1_strobe_gap", 32'(p1), 32'd0);
         if (q1.size() == 0) chk("u1_extra_strobe", 32'(q1.size()), 32'd1);
         else chk("u1_char", 32'(x1), 32'(q1.pop_front()));
      end
      p1 = c1;
   end

   always @(negedge clk) begin
      if (c2) begin
         n2++;
         chk("u2_strobe_gap", 32'(p2), 32'd0);
         if (q2.size() == 0) chk("u2_extra_strobe", 32'(q2.size()), 32'd1);
         else chk("u2_char", 32'(x2), 32'(q2.pop_front()));
      end
      p2 = c2;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, m;
      logic seen_done;
      rst = 1'b1;
      s0 = 0; s1 = 0; s2 = 0;
      r0 = 1; r1 = 1; r2 = 1;
      d0 = '0; d1 = '0; d2 = '0;
      tick(2);
      chk("rst_txdata", 32'(x0), 32'h00);
      chk("rst_txclk", 32'(c0), 32'd0);
      chk("rst_busy", 32'(b0), 32'd0);
      chk("rst_done", 32'(f0), 32'd0);
      rst = 1'b0;
      tick();

      // A5, txready held high
      d0 = 8'hA5;
      push_hex(0, 32'hA5, 2, 1, 1);
      s0 = 1; tick(); s0 = 0;
      chk("a5_busy_e0", 32'(b0), 32'd1);
      chk("a5_txclk_e0", 32'(c0), 32'd0);
      tick();
      chk("a5_txclk_e1", 32'(c0), 32'd1);
      chk("a5_txdata_e1", 32'(x0), 32'h41);
      wait_done(0, 20, n);
      chk("a5_done_edge", 32'(n + 1), 32'd8);
      chk("a5_busy_at_done", 32'(b0), 32'd0);
      chk("a5_txdata_held", 32'(x0), 32'h0A);
      chk("a5_strobes", 32'(n0), 32'd4);
      tick();
      chk("a5_done_clears", 32'(f0), 32'd0);
      chk("a5_queue_empty", 32'(q0.size()), 32'd0);

      // C0 with txready low for 10 cycles
      r0 = 0;
      d0 = 8'hC0;
      push_hex(0, 32'hC0, 2, 1, 1);
      m = n0;
      s0 = 1; tick(); s0 = 0;
      tick(10);
      chk("c0_stall_strobes", 32'(n0), 32'(m));
      chk("c0_stall_busy", 32'(b0), 32'd1);
      r0 = 1;
      wait_done(0, 20, n);
      chk("c0_done_edge", 32'(n), 32'd8);
      chk("c0_strobes", 32'(n0 - m), 32'd4);
      chk("c0_queue_empty", 32'(q0.size()), 32'd0);

      // start and data change while busy are ignored
      d0 = 8'h12;
      push_hex(0, 32'h12, 2, 1, 1);
      m = n0;
      s0 = 1; tick(); s0 = 0;
      tick(2);
      d0 = 8'hFF;
      s0 = 1; tick(); s0 = 0;
      wait_done(0, 20, n);
      chk("busy_start_done_edge", 32'(n + 3), 32'd8);
      tick(8);
      chk("busy_start_strobes", 32'(n0 - m), 32'd4);
      chk("busy_start_idle", 32'(b0), 32'd0);
      chk("busy_start_queue_empty", 32'(q0.size()), 32'd0);

      // reset after the second strobe
      d0 = 8'h7E;
      push_hex(0, 32'h7E, 2, 1, 1);
      m = n0;
      s0 = 1; tick(); s0 = 0;
      n = 0;
      while (n0 - m < 2 && n < 20) begin tick(); n++; end
      chk("rst_mid_two_strobes", 32'(n0 - m), 32'd2);
      chk("rst_mid_txdata_before", 32'(x0), 32'h45);
      rst = 1'b1;
      #1;
      chk("rst_mid_txclk", 32'(c0), 32'd0);
      chk("rst_mid_busy", 32'(b0), 32'd0);
      chk("rst_mid_txdata", 32'(x0), 32'h00);
      chk("rst_mid_done", 32'(f0), 32'd0);
      tick();
      rst = 1'b0;
      q0.delete();
      m = n0;
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen_done |= f0;
      end
      chk("rst_mid_no_done", 32'(seen_done), 32'd0);
      chk("rst_mid_no_resume", 32'(n0), 32'(m));
      d0 = 8'h09;
      push_hex(0, 32'h09, 2, 1, 1);
      s0 = 1; tick(); s0 = 0;
      wait_done(0, 20, n);
      chk("rst_mid_restart_done_edge", 32'(n), 32'd8);
      chk("rst_mid_restart_strobes", 32'(n0 - m), 32'd4);
      chk("rst_mid_restart_queue_empty", 32'(q0.size()), 32'd0);

      // lowercase, no CR/LF
      d1 = 8'h3F;
      push_hex(1, 32'h3F, 2, 0, 0);
      s1 = 1; tick(); s1 = 0;
      wait_done(1, 20, n);
      chk("u1_done_edge", 32'(n), 32'd4);
      tick(3);
      chk("u1_strobes", 32'(n1), 32'd2);
      chk("u1_queue_empty", 32'(q1.size()), 32'd0);

      // 16-bit, back-to-back start in the done cycle
      d2 = 16'h1234;
      push_hex(2, 32'h1234, 4, 1, 1);
      s2 = 1; tick(); s2 = 0;
      wait_done(2, 30, n);
      chk("u2_first_done_edge", 32'(n), 32'd12);
      d2 = 16'hBEEF;
      push_hex(2, 32'hBEEF, 4, 1, 1);
      s2 = 1; tick(); s2 = 0;
      chk("u2_b2b_accepted", 32'(b2), 32'd1);
      chk("u2_b2b_done_clears", 32'(f2), 32'd0);
      wait_done(2, 30, n);
      chk("u2_second_done_edge", 32'(n), 32'd12);
      chk("u2_strobes", 32'(n2), 32'd12);
      chk("u2_queue_empty", 32'(q2.size()), 32'd0);

      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
